reg_commit_ctrl: RTL and testbench
==================================

REG_COMMIT_CTRL -- requirements
Module: reg_commit_ctrl

Interface
REQ-001 Parameter ROB_TAGS, default 15, number of usable reorder tags; tags 1..15, tag 0 means "no rename".
REQ-002 clk_in  input  1  clock; all state updates on rising edge.
REQ-003 rst_in  input  1  reset, synchronous and active-low; sampled on rising edge of clk_in.
REQ-004 rdy_in  input  1  global ready; when low, all state holds.
REQ-005 dsp_valid  input  1  decoder presents one instruction.
REQ-006 dsp_has_rd  input  1  instruction writes a destination register.
REQ-007 dsp_rd  input  5  destination register index.
REQ-008 dsp_ready  output  1  controller can accept dispatch this cycle.
REQ-009 dsp_tag  output  4  tag allocated to the accepted instruction (current tail).
REQ-010 wb_valid  input  1  execution result broadcast.
REQ-011 wb_tag  input  4  tag of broadcast result.
REQ-012 wb_value  input  32  result value.
REQ-013 wb_mispredict  input  1  broadcast instruction requires a pipeline flush at commit.
REQ-014 rob2reg_reserve_enable / _rd (5) / _reorder (4)  output  rename request to the register file.
REQ-015 rob2reg_commit_enable / _des (5) / _value (32) / _reorder (4)  output  commit write to the register file.
REQ-016 flush_out  output  1  one-cycle flush pulse to the register file, reservation stations and fetch.
REQ-017 rob_count  output  4  number of occupied entries, 0..15.

Function
REQ-018 Storage: 15-entry circular buffer indexed by tag; fields busy, ready, has_rd, rd, value, mispredict.
REQ-019 Pointers head and tail run 1..15 and wrap 15->1; tag 0 is never allocated.
REQ-020 dsp_ready = rdy_in AND count<15 AND NOT flush_pending; count comes from registered state, with no same-cycle bypass of a commit.
REQ-021 Dispatch accepted when dsp_valid AND dsp_ready; at the edge: entry[tail] busy=1, ready=0, tail advances, count+1.
REQ-022 Reserve is combinational in the accept cycle: rob2reg_reserve_enable = accept AND dsp_has_rd AND dsp_rd!=0; _rd = dsp_rd; _reorder = tail.
REQ-023 Writeback with wb_valid and busy entry[wb_tag]: set ready, store value and mispredict; writeback to a non-busy tag or tag 0 is ignored.
REQ-024 Commit: at an edge where entry[head] is busy and ready, pop head (clear busy, head advances, count-1) and register commit outputs for exactly one cycle.
REQ-025 rob2reg_commit_enable = 1 only if the popped entry has_rd and rd!=0; _des, _value and _reorder carry the entry's rd, value and tag.
REQ-026 At most one commit per cycle, strictly in order; a ready entry behind a non-ready head waits.
REQ-027 Latency: writeback sampled at edge E0 to the head -> commit outputs valid between E1 and E2.
REQ-028 Simultaneous dispatch and commit in one cycle: count unchanged, both performed.
REQ-029 Simultaneous writeback and commit on the same tag cannot occur; writeback on the head is committed next edge.
REQ-030 Flush sequence, step 1: committing an entry with mispredict=1 still produces its commit write, and sets flush_pending.
REQ-031 Flush sequence, step 2: on the next edge, flush_out=1 for one cycle; all busy cleared; head=tail=1; count=0; flush_pending cleared.
REQ-032 During a flush no dispatch is accepted, writebacks are discarded and reserve is suppressed.
REQ-033 rdy_in low: no accept, no writeback capture, no pointer motion; commit_enable, reserve_enable and flush_out forced 0; state resumes unchanged when rdy_in returns high.

Reset
REQ-034 rst_in low at an edge: all busy/ready cleared, head=tail=1, count=0, flush_pending=0, all registered outputs 0; reset overrides rdy_in.
REQ-035 Reset mid-operation discards in-flight entries without a commit or flush_out pulse.
REQ-036 First dispatch after reset receives tag 1.

Verification
REQ-037 Basic flow: reset, dispatch rd=5 -> reserve_enable=1, tag 1; wb tag1 value 0x1234 -> commit_enable next cycle with des=5, value=0x1234, reorder=1.
REQ-038 Full and wrap: 15 dispatches -> dsp_ready=0, count=15; commit one -> dsp_ready=1; next tag = 1.
REQ-039 Out-of-order writeback: tags 1,2,3 dispatched; wb 3, then 2, then 1 -> commits in order 1,2,3 on consecutive cycles.
REQ-040 rd=0 and no-rd: dispatch rd=0 -> reserve_enable=0; commit pops the entry with commit_enable=0 and count decrements.
REQ-041 Mispredict: tags 1..4 busy; wb tag2 mispredict, wb tag1 -> commits 1 and 2, then flush_out pulse, count=0, next dispatch tag=1.
REQ-042 rdy_in held low 3 cycles during a pending commit -> no output activity; commit appears on the first cycle after rdy_in returns high.

Source files
------------

// File: rtl/reg_commit_ctrl.sv
// In-order commit controller: tag allocation at dispatch, writeback capture, one commit per cycle
// and a two-step flush after a mispredicted instruction commits.
module reg_commit_ctrl #(
  parameter int unsigned ROB_TAGS = 15
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic        dsp_valid,
  input  logic        dsp_has_rd,
  input  logic [4:0]  dsp_rd,
  output logic        dsp_ready,
  output logic [3:0]  dsp_tag,
  input  logic        wb_valid,
  input  logic [3:0]  wb_tag,
  input  logic [31:0] wb_value,
  input  logic        wb_mispredict,
  output logic        rob2reg_reserve_enable,
  output logic [4:0]  rob2reg_reserve_rd,
  output logic [3:0]  rob2reg_reserve_reorder,
  output logic        rob2reg_commit_enable,
  output logic [4:0]  rob2reg_commit_des,
  output logic [31:0] rob2reg_commit_value,
  output logic [3:0]  rob2reg_commit_reorder,
  output logic        flush_out,
  output logic [3:0]  rob_count
);

  localparam logic [3:0] MaxTag = 4'(ROB_TAGS);

  // Storage spans every 4-bit tag; slots above MaxTag (and slot 0) are never marked busy.
  logic [15:0] busy_q,  busy_d;
  logic [15:0] ready_q, ready_d;
  logic [15:0] hasrd_q, hasrd_d;
  logic [15:0] mp_q,    mp_d;
  logic [4:0]  rd_q    [16];
  logic [4:0]  rd_d    [16];
  logic [31:0] value_q [16];
  logic [31:0] value_d [16];

  logic [3:0]  head_q, head_d;
  logic [3:0]  tail_q, tail_d;
  logic [3:0]  count_q, count_d;
  logic        pend_q, pend_d;

  logic        cen_q, cen_d;
  logic [4:0]  cdes_q, cdes_d;
  logic [31:0] cval_q, cval_d;
  logic [3:0]  creo_q, creo_d;
  logic        flush_q, flush_d;

  logic        accept;
  logic        pop;
  logic        wb_hit;

  function automatic logic [3:0] next_tag(input logic [3:0] t);
    return (t == MaxTag) ? 4'd1 : t + 4'd1;
  endfunction

  assign dsp_ready = rdy_in & (count_q < MaxTag) & ~pend_q;
  assign accept    = dsp_valid & dsp_ready;
  assign dsp_tag   = tail_q;

  assign rob2reg_reserve_enable  = accept & dsp_has_rd & (dsp_rd != 5'd0);
  assign rob2reg_reserve_rd      = dsp_rd;
  assign rob2reg_reserve_reorder = tail_q;

  // Pulses stay registered while stalled so they are delivered once rdy_in returns.
  assign rob2reg_commit_enable  = cen_q & rdy_in;
  assign rob2reg_commit_des     = cdes_q;
  assign rob2reg_commit_value   = cval_q;
  assign rob2reg_commit_reorder = creo_q;
  assign flush_out              = flush_q & rdy_in;
  assign rob_count              = count_q;

  always_comb begin
    busy_d  = busy_q;
    ready_d = ready_q;
    hasrd_d = hasrd_q;
    mp_d    = mp_q;
    rd_d    = rd_q;
    value_d = value_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    pend_d  = pend_q;
    cen_d   = cen_q;
    cdes_d  = cdes_q;
    cval_d  = cval_q;
    creo_d  = creo_q;
    flush_d = flush_q;
    pop     = 1'b0;
    wb_hit  = 1'b0;

    if (rdy_in) begin
      cen_d   = 1'b0;
      flush_d = 1'b0;
      if (pend_q) begin
        busy_d  = '0;
        ready_d = '0;
        head_d  = 4'd1;
        tail_d  = 4'd1;
        count_d = 4'd0;
        pend_d  = 1'b0;
        flush_d = 1'b1;
      end else begin
        pop    = busy_q[head_q] & ready_q[head_q];
        wb_hit = wb_valid & (wb_tag != 4'd0) & busy_q[wb_tag];

        if (wb_hit) begin
          ready_d[wb_tag] = 1'b1;
          value_d[wb_tag] = wb_value;
          mp_d[wb_tag]    = wb_mispredict;
        end

        // Commit data comes from the pre-edge entry; a same-edge writeback to it is dropped.
        if (pop) begin
          busy_d[head_q]  = 1'b0;
          ready_d[head_q] = 1'b0;
          head_d          = next_tag(head_q);
          cen_d           = hasrd_q[head_q] & (rd_q[head_q] != 5'd0);
          cdes_d          = rd_q[head_q];
          cval_d          = value_q[head_q];
          creo_d          = head_q;
          pend_d          = mp_q[head_q];
        end

        if (accept) begin
          busy_d[tail_q]  = 1'b1;
          ready_d[tail_q] = 1'b0;
          hasrd_d[tail_q] = dsp_has_rd;
          rd_d[tail_q]    = dsp_rd;
          mp_d[tail_q]    = 1'b0;
          tail_d          = next_tag(tail_q);
        end

        count_d = count_q + 4'(accept) - 4'(pop);
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      busy_q  <= '0;
      ready_q <= '0;
      hasrd_q <= '0;
      mp_q    <= '0;
      for (int i = 0; i < 16; i++) begin
        rd_q[i]    <= '0;
        value_q[i] <= '0;
      end
      head_q  <= 4'd1;
      tail_q  <= 4'd1;
      count_q <= 4'd0;
      pend_q  <= 1'b0;
      cen_q   <= 1'b0;
      cdes_q  <= '0;
      cval_q  <= '0;
      creo_q  <= '0;
      flush_q <= 1'b0;
    end else begin
      busy_q  <= busy_d;
      ready_q <= ready_d;
      hasrd_q <= hasrd_d;
      mp_q    <= mp_d;
      rd_q    <= rd_d;
      value_q <= value_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      pend_q  <= pend_d;
      cen_q   <= cen_d;
      cdes_q  <= cdes_d;
      cval_q  <= cval_d;
      creo_q  <= creo_d;
      flush_q <= flush_d;
    end
  end

endmodule

// File: tb/tb_reg_commit_ctrl.sv
// Bench for reg_commit_ctrl: directed scenarios plus random traffic, all checked against an
// in-order queue model of the reorder buffer.
module tb_reg_commit_ctrl;

  logic        clk_in = 1'b0;
  logic        rst_in, rdy_in;
  logic        dsp_valid, dsp_has_rd;
  logic [4:0]  dsp_rd;
  logic        dsp_ready;
  logic [3:0]  dsp_tag;
  logic        wb_valid;
  logic [3:0]  wb_tag;
  logic [31:0] wb_value;
  logic        wb_mispredict;
  logic        rob2reg_reserve_enable;
  logic [4:0]  rob2reg_reserve_rd;
  logic [3:0]  rob2reg_reserve_reorder;
  logic        rob2reg_commit_enable;
  logic [4:0]  rob2reg_commit_des;
  logic [31:0] rob2reg_commit_value;
  logic [3:0]  rob2reg_commit_reorder;
  logic        flush_out;
  logic [3:0]  rob_count;

  always #5 clk_in = ~clk_in;

  reg_commit_ctrl #(.ROB_TAGS(15)) dut (
    .clk_in                 (clk_in),
    .rst_in                 (rst_in),
    .rdy_in                 (rdy_in),
    .dsp_valid              (dsp_valid),
    .dsp_has_rd             (dsp_has_rd),
    .dsp_rd                 (dsp_rd),
    .dsp_ready              (dsp_ready),
    .dsp_tag                (dsp_tag),
    .wb_valid               (wb_valid),
    .wb_tag                 (wb_tag),
    .wb_value               (wb_value),
    .wb_mispredict          (wb_mispredict),
    .rob2reg_reserve_enable (rob2reg_reserve_enable),
    .rob2reg_reserve_rd     (rob2reg_reserve_rd),
    .rob2reg_reserve_reorder(rob2reg_reserve_reorder),
    .rob2reg_commit_enable  (rob2reg_commit_enable),
    .rob2reg_commit_des     (rob2reg_commit_des),
    .rob2reg_commit_value   (rob2reg_commit_value),
    .rob2reg_commit_reorder (rob2reg_commit_reorder),
    .flush_out              (flush_out),
    .rob_count              (rob_count)
  );

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [3:0]  tag;
    logic        has_rd;
    logic [4:0]  rd;
    logic        rdy;
    logic [31:0] val;
    logic        mp;
  } ent_t;

  // Model: occupied entries in program order, plus what the last edge should have committed.
  ent_t        mq[$];
  logic [3:0]  m_next;
  logic        m_pend, m_cen, m_flush, m_pop_vld;
  logic [4:0]  m_des;
  logic [31:0] m_val;
  logic [3:0]  m_reo;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_edge();
    logic acc;
    ent_t e;
    acc = dsp_valid && rdy_in && (mq.size() < 15) && !m_pend;
    if (!rst_in) begin
      mq.delete();
      m_next = 4'd1; m_pend = 1'b0; m_cen = 1'b0; m_flush = 1'b0; m_pop_vld = 1'b1;
      m_des = '0; m_val = '0; m_reo = '0;
    end else if (rdy_in) begin
      m_cen   = 1'b0;
      m_flush = 1'b0;
      if (m_pend) begin
        mq.delete();
        m_next = 4'd1; m_pend = 1'b0; m_flush = 1'b1; m_pop_vld = 1'b0;
      end else begin
        m_pop_vld = 1'b0;
        if (mq.size() > 0 && mq[0].rdy) begin
          e = mq.pop_front();
          m_pop_vld = 1'b1;
          m_cen = e.has_rd && (e.rd != 5'd0);
          m_des = e.rd; m_val = e.val; m_reo = e.tag;
          if (e.mp) m_pend = 1'b1;
        end
        if (wb_valid) begin
          foreach (mq[i]) begin
            if (mq[i].tag == wb_tag) begin
              mq[i].rdy = 1'b1; mq[i].val = wb_value; mq[i].mp = wb_mispredict;
            end
          end
        end
        if (acc) begin
          e.tag = m_next; e.has_rd = dsp_has_rd; e.rd = dsp_rd;
          e.rdy = 1'b0; e.val = '0; e.mp = 1'b0;
          mq.push_back(e);
          m_next = (m_next == 4'd15) ? 4'd1 : m_next + 4'd1;
        end
      end
    end
  endtask

  // Check every output against the model mid-cycle, then advance one clock.
  task automatic tick();
    logic er, ea, eres;
    #3;
    er   = rdy_in && (mq.size() < 15) && !m_pend;
    ea   = dsp_valid && er;
    eres = ea && dsp_has_rd && (dsp_rd != 5'd0);
    check("dsp_ready", 32'(dsp_ready), 32'(er));
    check("dsp_tag", 32'(dsp_tag), 32'(m_next));
    check("rob_count", 32'(rob_count), 32'(mq.size()));
    check("reserve_en", 32'(rob2reg_reserve_enable), 32'(eres));
    if (eres) begin
      check("reserve_rd", 32'(rob2reg_reserve_rd), 32'(dsp_rd));
      check("reserve_reorder", 32'(rob2reg_reserve_reorder), 32'(m_next));
    end
    check("commit_en", 32'(rob2reg_commit_enable), 32'(m_cen && rdy_in));
    if (m_pop_vld && rdy_in) begin
      check("commit_des", 32'(rob2reg_commit_des), 32'(m_des));
      check("commit_value", rob2reg_commit_value, m_val);
      check("commit_reorder", 32'(rob2reg_commit_reorder), 32'(m_reo));
    end
    check("flush_out", 32'(flush_out), 32'(m_flush && rdy_in));
    @(posedge clk_in);
    model_edge();
    #1;
  endtask

  task automatic idle();
    dsp_valid = 1'b0; dsp_has_rd = 1'b0; dsp_rd = '0;
    wb_valid = 1'b0; wb_tag = '0; wb_value = '0; wb_mispredict = 1'b0;
  endtask

  task automatic dispatch(input logic [4:0] rd, input logic has);
    dsp_valid = 1'b1; dsp_has_rd = has; dsp_rd = rd;
    tick();
    idle();
  endtask

  task automatic writeback(input logic [3:0] tag, input logic [31:0] val, input logic mp);
    wb_valid = 1'b1; wb_tag = tag; wb_value = val; wb_mispredict = mp;
    tick();
    idle();
  endtask

  task automatic do_reset();
    rst_in = 1'b0;
    tick();
    rst_in = 1'b1;
  endtask

  logic [3:0] tg;

  initial begin
    idle();
    rst_in = 1'b0;
    rdy_in = 1'b1;
    @(posedge clk_in);
    model_edge();
    #1;
    do_reset();
    check("reset_count", 32'(rob_count), 32'd0);
    check("reset_tag", 32'(dsp_tag), 32'd1);

    // Basic flow
    dsp_valid = 1'b1; dsp_has_rd = 1'b1; dsp_rd = 5'd5;
    #2;
    check("basic_reserve", 32'(rob2reg_reserve_enable), 32'd1);
    check("basic_reorder", 32'(rob2reg_reserve_reorder), 32'd1);
    tick();
    idle();
    writeback(4'd1, 32'h1234, 1'b0);
    tick();
    check("basic_cen", 32'(rob2reg_commit_enable), 32'd1);
    check("basic_des", 32'(rob2reg_commit_des), 32'd5);
    check("basic_val", rob2reg_commit_value, 32'h1234);
    check("basic_reo", 32'(rob2reg_commit_reorder), 32'd1);
    tick();
    check("basic_pulse_end", 32'(rob2reg_commit_enable), 32'd0);

    // Full and wrap
    do_reset();
    for (int i = 0; i < 15; i++) dispatch(5'(i + 1), 1'b1);
    check("full_ready", 32'(dsp_ready), 32'd0);
    check("full_count", 32'(rob_count), 32'd15);
    writeback(4'd1, 32'haaaa, 1'b0);
    tick();
    check("after_pop_ready", 32'(dsp_ready), 32'd1);
    check("wrap_tag", 32'(dsp_tag), 32'd1);
    for (int t = 2; t <= 15; t++) writeback(4'(t), 32'(t * 3), 1'b0);
    tick();
    tick();
    check("drain_count", 32'(rob_count), 32'd0);

    // Out-of-order writeback, in-order commit
    dispatch(5'd7, 1'b1);
    dispatch(5'd8, 1'b1);
    dispatch(5'd9, 1'b1);
    writeback(4'd3, 32'h33, 1'b0);
    writeback(4'd2, 32'h22, 1'b0);
    writeback(4'd1, 32'h11, 1'b0);
    tick();
    check("ooo_first", 32'(rob2reg_commit_reorder), 32'd1);
    tick();
    check("ooo_second", 32'(rob2reg_commit_reorder), 32'd2);
    tick();
    check("ooo_third", 32'(rob2reg_commit_reorder), 32'd3);
    tick();

    // rd = 0 is popped without a register write
    tg = m_next;
    dsp_valid = 1'b1; dsp_has_rd = 1'b1; dsp_rd = 5'd0;
    #2;
    check("rd0_reserve", 32'(rob2reg_reserve_enable), 32'd0);
    tick();
    idle();
    writeback(tg, 32'hdead, 1'b0);
    tick();
    check("rd0_cen", 32'(rob2reg_commit_enable), 32'd0);
    check("rd0_count", 32'(rob_count), 32'd0);

    // Mispredict and flush
    do_reset();
    for (int i = 0; i < 4; i++) dispatch(5'(i + 1), 1'b1);
    writeback(4'd2, 32'hbad, 1'b1);
    writeback(4'd1, 32'h11, 1'b0);
    tick();
    check("mp_commit1", 32'(rob2reg_commit_reorder), 32'd1);
    tick();
    check("mp_commit2_en", 32'(rob2reg_commit_enable), 32'd1);
    check("mp_commit2", 32'(rob2reg_commit_reorder), 32'd2);
    check("mp_pending_ready", 32'(dsp_ready), 32'd0);
    tick();
    check("mp_flush", 32'(flush_out), 32'd1);
    check("mp_count", 32'(rob_count), 32'd0);
    check("mp_next_tag", 32'(dsp_tag), 32'd1);
    tick();
    check("mp_flush_end", 32'(flush_out), 32'd0);
    dispatch(5'd3, 1'b1);

    // rdy_in stall over a pending commit
    do_reset();
    dispatch(5'd6, 1'b1);
    writeback(4'd1, 32'h55, 1'b0);
    rdy_in = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall_cen", 32'(rob2reg_commit_enable), 32'd0);
      check("stall_count", 32'(rob_count), 32'd1);
    end
    rdy_in = 1'b1;
    tick();
    check("resume_cen", 32'(rob2reg_commit_enable), 32'd1);
    check("resume_val", rob2reg_commit_value, 32'h55);

    // Random traffic
    for (int c = 0; c < 1500; c++) begin
      rst_in        = ($urandom_range(0, 199) != 0);
      rdy_in        = ($urandom_range(0, 7) != 0);
      dsp_valid     = 1'($urandom_range(0, 1));
      dsp_has_rd    = ($urandom_range(0, 3) != 0);
      dsp_rd        = 5'($urandom_range(0, 31));
      wb_valid      = ($urandom_range(0, 2) != 0);
      if (mq.size() > 0 && $urandom_range(0, 3) != 0)
        wb_tag = mq[$urandom_range(0, mq.size() - 1)].tag;
      else
        wb_tag = 4'($urandom_range(0, 15));
      wb_value      = $urandom;
      wb_mispredict = ($urandom_range(0, 24) == 0);
      tick();
    end
    idle();
    rst_in = 1'b1;
    rdy_in = 1'b1;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
